cic_comp_fir: RTL and testbench

Compensating FIR decimation-rate post-filter for the CIC decimator output.
- Consumes the CIC's 8-bit signed sample and its `d_clk` rate strobe.
- Applies a fixed 15-tap symmetric FIR with a serial multiply-accumulate (MAC) to flatten the CIC passband droop.
- Delivers a rescaled 8-bit signed sample with a one-cycle valid pulse to the demodulator.
- Runs entirely in the system `clk` domain; no clock crossing.

---
 rtl/cic_comp_pkg.sv | 29 ++
 rtl/cic_comp_ring.sv | 44 ++++
 rtl/cic_comp_fir.sv | 131 +++++++++++++
 tb/tb_cic_comp_fir.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// ============================================================================
// Module      : cic_comp_pkg
// Description : Shared constants, coefficient table and FSM state type for
//               the CIC compensating FIR post-filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cic_comp_pkg;

    localparam int TAPS   = 15;
    localparam int COEF_W = 10;

    // Symmetric droop-compensation taps; they sum to 512 for unity DC gain.
    localparam logic signed [COEF_W-1:0] c_coef [TAPS] = '{
        -10'sd4, -10'sd8, 10'sd0, 10'sd16, -10'sd16, -10'sd32, 10'sd64,
        10'sd472,
        10'sd64, -10'sd32, -10'sd16, 10'sd16, 10'sd0, -10'sd8, -10'sd4
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cic_comp_ring.sv
// ============================================================================
// Module      : cic_comp_ring
// Description : 15 x 8-bit sample ring with wrapping write pointer and a
//               combinational read port addressed by age (0 = newest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comp_ring
    import cic_comp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] wdata,
    input  logic [3:0] rd_off,
    output logic [7:0] rdata
);

    logic [7:0] r_mem [TAPS];
    logic [3:0] r_wp;
    logic [4:0] w_sum;
    logic [3:0] w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
            r_wp <= '0;
        end else if (we) begin
            r_mem[r_wp] <= wdata;
            r_wp        <= (r_wp == 4'(TAPS - 1)) ? 4'd0 : r_wp + 4'd1;
        end
    end

    // Newest entry sits at wp-1; adding TAPS-1 keeps the sum non-negative.
    assign w_sum = 5'(r_wp) + 5'(TAPS - 1) - 5'(rd_off);
    assign w_idx = (w_sum >= 5'(TAPS)) ? 4'(w_sum - 5'(TAPS)) : w_sum[3:0];
    assign rdata = r_mem[w_idx];

endmodule

`default_nettype wire

// File: rtl/cic_comp_fir.sv
// ============================================================================
// Module      : cic_comp_fir
// Description : 15-tap serial-MAC FIR compensating CIC droop; one 8-bit
//               output per d_clk rising edge. Define CIC_COMP_SAT_EN to
//               saturate the output instead of wrapping it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    input  logic       d_clk,
    output logic [7:0] d_out,
    output logic       d_valid,
    output logic       overrun
);

    localparam int PROD_W = 8 + COEF_W;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_d_clk_q;
    logic                      w_cap;
    logic                      w_we;
    logic [3:0]                r_k;
    logic signed [ACC_W-1:0]   r_acc;
    logic [7:0]                w_rdata;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic [7:0]                w_dout;

    // Tracks d_clk even during reset so a strobe held high across reset
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        r_d_clk_q <= d_clk;
    end

    assign w_cap = d_clk & ~r_d_clk_q;
    assign w_we  = w_cap && (r_state == IDLE);

    cic_comp_ring u_ring (
        .clk    (clk),
        .rst    (rst),
        .we     (w_we),
        .wdata  (d_in),
        .rd_off (r_k),
        .rdata  (w_rdata)
    );

    assign w_prod     = $signed(w_rdata) * c_coef[r_k];
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_W-1:0] c_pos_max = 127;
    localparam logic signed [ACC_W-1:0] c_neg_min = -128;
    logic signed [ACC_W-1:0] w_r;

    assign w_r = r_acc >>> SHIFT;

    always_comb begin
        w_dout = w_r[7:0];
        if (w_r > c_pos_max) begin
            w_dout = 8'h7F;
        end else if (w_r < c_neg_min) begin
            w_dout = 8'h80;
        end
    end
`else
    assign w_dout = r_acc[SHIFT+7:SHIFT];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cap) w_state_nxt = MAC;
            MAC:     if (r_k == 4'(TAPS - 1)) w_state_nxt = OUT;
            OUT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_k     <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            if (w_cap && (r_state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_cap) begin
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + 4'd1;
                end
                OUT: begin
                    d_out   <= w_dout;
                    d_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cic_comp_fir.sv
// ============================================================================
// Module      : tb_cic_comp_fir
// Description : Scoreboard bench for cic_comp_fir against a direct-form
//               convolution model over the history of accepted samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_comp_fir;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_in;
    logic       d_clk;
    logic [7:0] d_out;
    logic       d_valid;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cnt = 0;

    int coef [15] = '{-4, -8, 0, 16, -16, -32, 64, 472, 64, -32, -16, 16, 0, -8, -4};
    int hist [$];
    int exp_val [$];
    int exp_cyc [$];
    int last_acc;
    int exp_ovr;

    cic_comp_fir #(.ACC_W(24), .SHIFT(9)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .d_clk   (d_clk),
        .d_out   (d_out),
        .d_valid (d_valid),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_out();
        int acc = 0;
        int r;
        for (int k = 0; k < 15; k++) begin
            acc += coef[k] * hist[hist.size() - 1 - k];
        end
        r = acc >>> 9;
`ifdef CIC_COMP_SAT_EN
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`else
        r = r & 255;
        if (r > 127) r -= 256;
`endif
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (15) hist.push_back(0);
        exp_val.delete();
        exp_cyc.delete();
        last_acc = -1000;
        exp_ovr  = 0;
    endtask

    // A strobe is taken only if at least 17 cycles have passed since the
    // last accepted one; otherwise it is lost and flags overrun.
    task automatic model_strobe(input int v, input int c);
        if (c - last_acc >= 17) begin
            hist.push_back(v);
            void'(hist.pop_front());
            exp_val.push_back(model_out());
            exp_cyc.push_back(c + 16);
            last_acc = c;
        end else begin
            exp_ovr = 1;
        end
    endtask

    task automatic send(input int v, input int sp);
        int vv;
        vv = v;
        @(negedge clk);
        d_in  = vv[7:0];
        d_clk = 1'b1;
        @(posedge clk);
        #1;
        model_strobe(v, cyc);
        chk("overrun", int'(overrun), exp_ovr);
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_clk = 1'b0;
        repeat (sp - 3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && d_valid) begin
            valid_cnt++;
            if (exp_val.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: d_out=%0d at cycle %0d, none expected",
                         $signed(d_out), cyc);
            end else begin
                chk("d_out", int'($signed(d_out)), exp_val.pop_front());
                chk("latency", cyc, exp_cyc.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        d_clk = 1'b0;
        d_in  = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_d_out", int'(d_out), 0);
        chk("reset_d_valid", int'(d_valid), 0);
        chk("reset_overrun", int'(overrun), 0);

        // DC
        repeat (30) send(64, 40);

        // Impulse
        send(100, 20);
        repeat (20) send(0, 20);

        // Overflow: sign pattern of the coefficients at full scale
        for (int k = 0; k < 15; k++) begin
            send((coef[14 - k] > 0) ? 127 : ((coef[14 - k] < 0) ? -127 : 0), 20);
        end
        repeat (5) @(posedge clk);
`ifdef CIC_COMP_SAT_EN
        chk("overflow_const", int'($signed(d_out)), 127);
`else
        chk("overflow_const", int'($signed(d_out)), -70);
`endif

        // Overrun: 10-cycle spacing
        repeat (8) send(int'($urandom_range(0, 255)) - 128, 10);
        repeat (20) @(posedge clk);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset at edge 5 of a MAC, with d_clk held high through reset
        @(negedge clk);
        d_in  = 8'd55;
        d_clk = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        valid_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("abort_d_out", int'(d_out), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_no_valid", valid_cnt, 0);
        d_clk = 1'b0;

        // Impulse rerun on a freshly cleared ring
        send(100, 20);
        repeat (16) send(0, 20);

        // Ramp across several pointer wraps at minimum spacing
        for (int i = -20; i < 20; i++) send(i, 17);

        // Random samples with random legal spacing
        repeat (30) send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(17, 24)));

        repeat (20) @(posedge clk);
        chk("drain", exp_val.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
